// File: rtl/toggle_cover_detector.sv
// Per-signal rise/fall detector feeding the toggle-coverage reporter.
// Tracks a sticky covered bitmap, a saturating count of new points, and an all-covered flag.
module toggle_cover_detector #(
    parameter int unsigned SIG_WIDTH = 65,
    parameter bit          NEW_ONLY  = 1'b1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                   gbl_clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   clear,
    input  logic [SIG_WIDTH-1:0]   sig,
    output logic [2*SIG_WIDTH-1:0] valid,
    output logic [CNT_W-1:0]       new_count,
    output logic                   all_covered
);

    localparam int unsigned VW = 2 * SIG_WIDTH;
    localparam int unsigned PW = $clog2(VW + 1);
    localparam int unsigned SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

    logic [SIG_WIDTH-1:0] prev_q;
    logic                 prev_valid_q;
    logic [VW-1:0]        covered_q;

    logic [VW-1:0]        hit;
    logic [VW-1:0]        fresh;
    logic [VW-1:0]        covered_d;
    logic [PW-1:0]        fresh_cnt;
    logic [SW-1:0]        cnt_sum;
    logic [CNT_W-1:0]     count_d;

    // prev_valid_q gates the first sample after reset so the zero baseline never fires.
    always_comb begin
        hit = '0;
        for (int i = 0; i < SIG_WIDTH; i++) begin
            hit[2*i]   = en & prev_valid_q & sig[i] & ~prev_q[i];
            hit[2*i+1] = en & prev_valid_q & ~sig[i] & prev_q[i];
        end
    end

    assign fresh     = hit & ~covered_q;
    assign covered_d = covered_q | hit;

    always_comb begin
        fresh_cnt = '0;
        for (int j = 0; j < VW; j++) begin
            fresh_cnt = fresh_cnt + PW'(fresh[j]);
        end
    end

    assign cnt_sum = SW'(new_count) + SW'(fresh_cnt);
    assign count_d = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            covered_q    <= '0;
            valid        <= '0;
            new_count    <= '0;
            all_covered  <= 1'b0;
        end else begin
            // Sampling continues through en-low and clear so re-enabling never sees stale edges.
            prev_q       <= sig;
            prev_valid_q <= 1'b1;
            if (clear) begin
                covered_q   <= '0;
                valid       <= '0;
                new_count   <= '0;
                all_covered <= 1'b0;
            end else begin
                covered_q   <= covered_d;
                valid       <= NEW_ONLY ? fresh : hit;
                new_count   <= count_d;
                all_covered <= &covered_d;
            end
        end
    end

endmodule

// File: tb/tb_toggle_cover_detector.sv
// Randomised and directed bench for toggle_cover_detector; runs NEW_ONLY=1 and NEW_ONLY=0
// instances side by side against an event-list reference model.
module tb_toggle_cover_detector;

    localparam int NS = 65;
    localparam int NV = 2 * NS;

    logic          gbl_clk = 1'b0;
    logic          reset   = 1'b0;
    logic          en      = 1'b1;
    logic          clear   = 1'b0;
    logic [NS-1:0] sig     = '0;

    logic [NV-1:0] valid_new, valid_all;
    logic [7:0]    cnt_new, cnt_all;
    logic          allc_new, allc_all;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [NS-1:0] m_prev;
    bit            m_pv;
    bit            m_cov [NV];
    int            m_cnt;
    bit            m_all;
    logic [NV-1:0] m_v_new, m_v_all;

    always #5 gbl_clk = ~gbl_clk;

    toggle_cover_detector #(.SIG_WIDTH(NS), .NEW_ONLY(1'b1), .CNT_W(8)) u_dut_new (
        .gbl_clk     (gbl_clk),
        .reset       (reset),
        .en          (en),
        .clear       (clear),
        .sig         (sig),
        .valid       (valid_new),
        .new_count   (cnt_new),
        .all_covered (allc_new)
    );

    toggle_cover_detector #(.SIG_WIDTH(NS), .NEW_ONLY(1'b0), .CNT_W(8)) u_dut_all (
        .gbl_clk     (gbl_clk),
        .reset       (reset),
        .en          (en),
        .clear       (clear),
        .sig         (sig),
        .valid       (valid_all),
        .new_count   (cnt_all),
        .all_covered (allc_all)
    );

    task automatic check(input string tag, input logic [NV-1:0] got, input logic [NV-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply the current inputs to the model, clock once, then compare both instances.
    task automatic step();
        logic [NV-1:0] ev;
        ev = '0;
        m_v_new = '0;
        if (!reset) begin
            m_prev = '0;
            m_pv   = 1'b0;
            foreach (m_cov[k]) m_cov[k] = 1'b0;
            m_cnt  = 0;
            m_all  = 1'b0;
        end else begin
            if (en && m_pv) begin
                for (int i = 0; i < NS; i++)
                    if (sig[i] != m_prev[i]) ev[2*i + (sig[i] ? 0 : 1)] = 1'b1;
            end
            if (clear) begin
                foreach (m_cov[k]) m_cov[k] = 1'b0;
                m_cnt = 0;
                m_all = 1'b0;
                ev    = '0;
            end else begin
                for (int j = 0; j < NV; j++) begin
                    if (ev[j] && !m_cov[j]) begin
                        m_v_new[j] = 1'b1;
                        m_cov[j]   = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
                m_all = 1'b1;
                foreach (m_cov[k]) if (!m_cov[k]) m_all = 1'b0;
            end
            m_prev = sig;
            m_pv   = 1'b1;
        end
        m_v_all = ev;
        @(posedge gbl_clk);
        #1;
        check("valid_new", valid_new, m_v_new);
        check("valid_all", valid_all, m_v_all);
        check("count_new", NV'(cnt_new), NV'(m_cnt));
        check("count_all", NV'(cnt_all), NV'(m_cnt));
        check("allcov_new", NV'(allc_new), NV'(m_all));
        check("allcov_all", NV'(allc_all), NV'(m_all));
    endtask

    task automatic do_reset(input logic [NS-1:0] s, input int cycles);
        reset = 1'b0;
        sig   = s;
        repeat (cycles) step();
        reset = 1'b1;
    endtask

    initial begin
        logic [NS-1:0] mask;
        int pulses;

        // Baseline suppression with all-ones held through and after reset
        en = 1'b1;
        clear = 1'b0;
        do_reset('1, 2);
        repeat (4) begin
            step();
            check("baseline_valid", valid_new, '0);
            check("baseline_count", NV'(cnt_new), '0);
        end

        // Single rise then fall on sig[3]
        do_reset('0, 1);
        step();
        sig[3] = 1'b1;
        step();
        check("rise3_bit6", NV'(valid_new[6]), NV'(1));
        check("rise3_count", NV'(cnt_new), NV'(1));
        step();
        check("rise3_one_cycle", valid_new, '0);
        sig[3] = 1'b0;
        step();
        check("fall3_bit7", NV'(valid_new[7]), NV'(1));
        check("fall3_count", NV'(cnt_new), NV'(2));
        sig[3] = 1'b1;
        step();
        sig[3] = 1'b0;
        step();
        check("repeat3_valid", valid_new, '0);
        check("repeat3_count", NV'(cnt_new), NV'(2));

        // Every-toggle mode on sig[0]
        pulses = 0;
        for (int t = 0; t < 4; t++) begin
            sig[0] = ~sig[0];
            step();
            pulses += int'(valid_all[0]) + int'(valid_all[1]);
        end
        check("toggle0_pulses", NV'(pulses), NV'(4));

        // Bulk up/down and all_covered
        clear = 1'b1;
        step();
        clear = 1'b0;
        sig = '1;
        step();
        check("bulk_up_count", NV'(cnt_new), NV'(65));
        sig = '0;
        step();
        check("bulk_dn_count", NV'(cnt_new), NV'(130));
        check("bulk_allcov", NV'(allc_new), NV'(1));
        repeat (3) begin
            sig = ~sig;
            step();
        end
        check("bulk_sat_count", NV'(cnt_new), NV'(130));

        // en gating on sig[10]
        clear = 1'b1;
        sig   = '0;
        step();
        clear = 1'b0;
        en = 1'b0;
        sig[10] = 1'b1;
        step();
        en = 1'b1;
        step();
        check("en_no_bit20", NV'(valid_all[20]), NV'(0));
        sig[10] = 1'b0;
        step();
        check("en_fall_bit21", NV'(valid_all[21]), NV'(1));

        // clear beats a same-cycle rise of sig[5]
        clear   = 1'b1;
        sig[5]  = 1'b1;
        step();
        clear   = 1'b0;
        check("clear_valid", valid_all, '0);
        check("clear_count", NV'(cnt_new), NV'(0));
        sig[5] = 1'b0;
        step();
        check("clear_fall_bit11", NV'(valid_new[11]), NV'(1));
        check("clear_fall_count", NV'(cnt_new), NV'(1));

        // Randomised run
        for (int c = 0; c < 400; c++) begin
            mask = '0;
            if ($urandom_range(0, 9) == 0) begin
                mask = {$urandom(), $urandom(), $urandom()};
            end else begin
                repeat ($urandom_range(0, 3)) mask[$urandom_range(0, NS - 1)] = 1'b1;
            end
            sig   = sig ^ mask;
            en    = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 59) != 0);
            step();
        end
        reset = 1'b1;
        en    = 1'b1;
        clear = 1'b0;
        sig   = '1;
        step();
        step();

        // Reset mid-run
        reset = 1'b0;
        sig   = '0;
        step();
        check("midreset_valid", valid_all, '0);
        check("midreset_count", NV'(cnt_new), '0);
        check("midreset_allcov", NV'(allc_new), '0);
        reset = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
